// File: rtl/fp_result_collector.sv
// First-word-fall-through result FIFO on the floating_point_add output stream.
// Optional NaN flag on the head entry: define FP_COLLECT_NAN_DETECT_EN.
module fp_result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  validIn,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  readIn,
  input  logic                  clearIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic [ADDR_WIDTH:0]   countOut,
  output logic                  fullOut,
  output logic                  overflowOut,
  output logic                  nanOut
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT =
    (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  push;
  logic                  pop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign pop  = readIn & validOut;
  assign push = validIn & (~fullOut | pop);

  assign countOut = wr_ptr - rd_ptr;
  assign fullOut  = (countOut == FULL_COUNT);
  assign validOut = (wr_ptr != rd_ptr);
  assign dataOut  = mem[rd_ptr[ADDR_WIDTH-1:0]];

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflowOut <= 1'b0;
    end else if (clearIn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflowOut <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (validIn & fullOut & ~pop)
        overflowOut <= 1'b1;
    end
  end

  always_ff @(posedge clkIn) begin
    if (push & ~clearIn)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= dataIn;
  end

`ifdef FP_COLLECT_NAN_DETECT_EN
  assign nanOut = validOut
                & (dataOut[30:23] == 8'hFF)
                & (dataOut[22:0] != 23'd0);
`else
  assign nanOut = 1'b0;
`endif

endmodule

// File: tb/tb_fp_result_collector.sv
// Directed bench for fp_result_collector (DEPTH=16).
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_fp_result_collector;

  localparam int DW = 32;
  localparam int AW = 4;

`ifdef FP_COLLECT_NAN_DETECT_EN
  localparam bit NAN_EN = 1'b1;
`else
  localparam bit NAN_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          read_in = 1'b0;
  logic          clear_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [AW:0]   count_out;
  logic          full_out;
  logic          overflow_out;
  logic          nan_out;

  int checks = 0;
  int errors = 0;

  fp_result_collector #(
    .DATA_WIDTH(DW),
    .DEPTH(16),
    .ADDR_WIDTH(AW)
  ) dut (
    .clkIn(clk),
    .rstIn(rst_n),
    .validIn(valid_in),
    .dataIn(data_in),
    .readIn(read_in),
    .clearIn(clear_in),
    .dataOut(data_out),
    .validOut(valid_out),
    .countOut(count_out),
    .fullOut(full_out),
    .overflowOut(overflow_out),
    .nanOut(nan_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    read_in  = 1'b0;
    clear_in = 1'b0;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    valid_in = 1'b1;
    data_in  = w;
    step();
    idle();
  endtask

  task automatic test_reset();
    checks++;
    if (count_out !== 5'd0 || valid_out !== 1'b0 || full_out !== 1'b0 ||
        overflow_out !== 1'b0 || nan_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d valid=%b full=%b ovf=%b nan=%b want 0 0 0 0 0",
               count_out, valid_out, full_out, overflow_out, nan_out);
    end
    rst_n = 1'b1;
    step();
    push_word(32'h1111_0001);
    push_word(32'h1111_0002);
    push_word(32'h1111_0003);
    checks++;
    if (count_out !== 5'd3) begin
      errors++;
      $display("FAIL reset_prefill: count=%0d want 3", count_out);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count_out !== 5'd0 || valid_out !== 1'b0 || overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: count=%0d valid=%b ovf=%b want 0 0 0",
               count_out, valid_out, overflow_out);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_order();
    logic [DW-1:0] w [3];
    w[0] = 32'h3F80_0000;
    w[1] = 32'h4000_0000;
    w[2] = 32'h4040_0000;
    for (int i = 0; i < 3; i++) begin
      push_word(w[i]);
      checks++;
      if (count_out !== 5'(i + 1) || valid_out !== 1'b1) begin
        errors++;
        $display("FAIL order_push%0d: count=%0d valid=%b want %0d 1",
                 i, count_out, valid_out, i + 1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data_out !== w[i]) begin
        errors++;
        $display("FAIL order_data%0d: got %h want %h", i, data_out, w[i]);
      end
      read_in = 1'b1;
      step();
      idle();
      checks++;
      if (count_out !== 5'(2 - i)) begin
        errors++;
        $display("FAIL order_pop%0d: count=%0d want %0d", i, count_out, 2 - i);
      end
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL order_empty: valid=%b want 0", valid_out);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 16; i++)
      push_word(32'h0000_1000 + i);
    checks++;
    if (full_out !== 1'b1 || count_out !== 5'd16 || overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: full=%b count=%0d ovf=%b want 1 16 0",
               full_out, count_out, overflow_out);
    end
    push_word(32'hDEAD_BEEF);
    checks++;
    if (overflow_out !== 1'b1 || count_out !== 5'd16) begin
      errors++;
      $display("FAIL ovf_drop: ovf=%b count=%0d want 1 16",
               overflow_out, count_out);
    end
    for (int i = 1; i <= 16; i++) begin
      checks++;
      if (data_out !== 32'h0000_1000 + i) begin
        errors++;
        $display("FAIL ovf_data%0d: got %h want %h",
                 i, data_out, 32'h0000_1000 + i);
      end
      read_in = 1'b1;
      step();
      idle();
    end
    checks++;
    if (valid_out !== 1'b0 || overflow_out !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: valid=%b ovf=%b want 0 1",
               valid_out, overflow_out);
    end
    push_word(32'h0000_0042);
    clear_in = 1'b1;
    valid_in = 1'b1;
    data_in  = 32'h0BAD_0BAD;
    step();
    idle();
    checks++;
    if (overflow_out !== 1'b0 || count_out !== 5'd0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b count=%0d valid=%b want 0 0 0",
               overflow_out, count_out, valid_out);
    end
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 16; i++)
      push_word(32'h0000_2000 + i);
    valid_in = 1'b1;
    data_in  = 32'hAAAA_5555;
    read_in  = 1'b1;
    step();
    idle();
    checks++;
    if (count_out !== 5'd16 || full_out !== 1'b1 || overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL full_pp: count=%0d full=%b ovf=%b want 16 1 0",
               count_out, full_out, overflow_out);
    end
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (data_out !== 32'h0000_2000 + i) begin
        errors++;
        $display("FAIL full_pp_data%0d: got %h want %h",
                 i, data_out, 32'h0000_2000 + i);
      end
      read_in = 1'b1;
      step();
      idle();
    end
    checks++;
    if (data_out !== 32'hAAAA_5555 || count_out !== 5'd1) begin
      errors++;
      $display("FAIL full_pp_new: data=%h count=%0d want aaaa5555 1",
               data_out, count_out);
    end
    read_in = 1'b1;
    step();
    idle();
  endtask

  task automatic test_empty_pushpop();
    valid_in = 1'b1;
    data_in  = 32'h4120_0000;
    read_in  = 1'b1;
    step();
    idle();
    checks++;
    if (count_out !== 5'd1 || data_out !== 32'h4120_0000 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL empty_pp: count=%0d data=%h valid=%b want 1 41200000 1",
               count_out, data_out, valid_out);
    end
    read_in = 1'b1;
    step();
    idle();
    read_in = 1'b1;
    step();
    step();
    idle();
    checks++;
    if (count_out !== 5'd0 || valid_out !== 1'b0 || overflow_out !== 1'b0) begin
      errors++;
      $display("FAIL empty_read: count=%0d valid=%b ovf=%b want 0 0 0",
               count_out, valid_out, overflow_out);
    end
    push_word(32'h4130_0000);
    checks++;
    if (count_out !== 5'd1 || data_out !== 32'h4130_0000) begin
      errors++;
      $display("FAIL empty_after: count=%0d data=%h want 1 41300000",
               count_out, data_out);
    end
    read_in = 1'b1;
    step();
    idle();
  endtask

  task automatic test_nan();
    push_word(32'h7FC0_0000);
    checks++;
    if (nan_out !== NAN_EN) begin
      errors++;
      $display("FAIL nan_qnan: nan=%b want %b", nan_out, NAN_EN);
    end
    read_in = 1'b1;
    step();
    idle();
    push_word(32'h7F80_0000);
    checks++;
    if (nan_out !== 1'b0) begin
      errors++;
      $display("FAIL nan_inf: nan=%b want 0", nan_out);
    end
    read_in = 1'b1;
    step();
    idle();
    push_word(32'hFF80_0001);
    checks++;
    if (nan_out !== NAN_EN) begin
      errors++;
      $display("FAIL nan_neg: nan=%b want %b", nan_out, NAN_EN);
    end
    read_in = 1'b1;
    step();
    idle();
    checks++;
    if (nan_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL nan_empty: nan=%b valid=%b want 0 0", nan_out, valid_out);
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_order();
    test_overflow();
    test_full_pushpop();
    test_empty_pushpop();
    test_nan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
